mipi_byte_align_ctrl: RTL and testbench

Sequencing controller for the MIPI CSI-2 byte aligner on one data lane. On every high-speed burst it re-arms the aligner's offset search, waits a bounded time for the aligner to report valid, retries on timeout, and forces a re-search when the downstream packet parser reports repeated header ECC errors. It sits between the lane PHY/HS-detect logic, the byte aligner, and the packet parser. It exports lock status and error counters for debug.

---
 rtl/mipi_byte_align_ctrl_if.sv | 42 ++++
 rtl/mipi_byte_align_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mipi_byte_align_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_byte_align_ctrl_if.sv
// Signal bundle between the byte-align sequencing controller and its lane environment.
// The slave modport is the controller's view; master is the PHY/aligner/parser side.
interface mipi_byte_align_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             I_Lane_HS_Active;
    logic             I_Align_Vaild;
    logic             I_Packet_Done;
    logic             I_Ecc_Error;
    logic             O_ReSearch_Offset;
    logic             O_Lock;
    logic             O_Fail;
    logic [2:0]       O_State;
    logic [CNT_W-1:0] O_Lock_Lost_Cnt;
    logic [CNT_W-1:0] O_Timeout_Cnt;

    modport slave (
        input  I_Lane_HS_Active,
        input  I_Align_Vaild,
        input  I_Packet_Done,
        input  I_Ecc_Error,
        output O_ReSearch_Offset,
        output O_Lock,
        output O_Fail,
        output O_State,
        output O_Lock_Lost_Cnt,
        output O_Timeout_Cnt
    );

    modport master (
        output I_Lane_HS_Active,
        output I_Align_Vaild,
        output I_Packet_Done,
        output I_Ecc_Error,
        input  O_ReSearch_Offset,
        input  O_Lock,
        input  O_Fail,
        input  O_State,
        input  O_Lock_Lost_Cnt,
        input  O_Timeout_Cnt
    );
endinterface

// File: rtl/mipi_byte_align_ctrl.sv
// Per-lane byte-aligner sequencer: re-arms offset search on each HS burst, retries on
// sync timeout, forces re-search on repeated header ECC errors, and keeps debug counters.
module mipi_byte_align_ctrl #(
    parameter int SYNC_TIMEOUT = 64,
    parameter int ERR_LIMIT    = 2,
    parameter int MAX_RETRY    = 8,
    parameter int CNT_W        = 16
) (
    input  logic                  I_CLK,
    input  logic                  I_Rst_n,
    mipi_byte_align_ctrl_if.slave bus
);

    localparam int TMR_W = $clog2(SYNC_TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int ECC_W = $clog2(ERR_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [RTY_W-1:0] r_retry;
    logic [ECC_W-1:0] r_ecc;
    logic             r_research;
    logic             r_lock;
    logic             r_fail;
    logic [CNT_W-1:0] r_lock_lost_cnt;
    logic [CNT_W-1:0] r_timeout_cnt;

    logic             w_lane_drop;
    logic             w_timer_exp;
    logic [RTY_W-1:0] w_retry_inc;
    logic             w_retry_exh;
    logic [ECC_W-1:0] w_ecc_inc;
    logic             w_ecc_lim;

    // Debug counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    assign w_lane_drop = (!bus.I_Lane_HS_Active) && (r_state != ST_IDLE);
    assign w_timer_exp = (r_timer == TMR_W'(SYNC_TIMEOUT - 1));
    assign w_retry_inc = r_retry + RTY_W'(1);
    assign w_retry_exh = (w_retry_inc >= RTY_W'(MAX_RETRY));
    assign w_ecc_inc   = r_ecc + ECC_W'(1);
    assign w_ecc_lim   = (w_ecc_inc >= ECC_W'(ERR_LIMIT));

    // Sequencing FSM with all outputs registered; lane drop overrides every state.
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_state         <= ST_IDLE;
            r_timer         <= '0;
            r_retry         <= '0;
            r_ecc           <= '0;
            r_research      <= 1'b0;
            r_lock          <= 1'b0;
            r_fail          <= 1'b0;
            r_lock_lost_cnt <= '0;
            r_timeout_cnt   <= '0;
        end else begin
            r_research <= 1'b0;
            if (w_lane_drop) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
                r_retry <= '0;
                r_ecc   <= '0;
                r_lock  <= 1'b0;
                r_fail  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_lock <= 1'b0;
                        r_fail <= 1'b0;
                        if (bus.I_Lane_HS_Active) begin
                            r_state    <= ST_ARM;
                            r_research <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ARM: begin
                        r_state <= ST_WAIT_SYNC;
                        r_timer <= '0;
                        r_ecc   <= '0;
                        r_lock  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                    ST_WAIT_SYNC: begin
                        // Valid takes precedence over a coincident timeout.
                        if (bus.I_Align_Vaild) begin
                            r_state <= ST_LOCKED;
                            r_lock  <= 1'b1;
                            r_fail  <= 1'b0;
                            r_retry <= '0;
                            r_timer <= '0;
                        end else if (w_timer_exp) begin
                            r_timeout_cnt <= sat_inc(r_timeout_cnt);
                            r_retry       <= w_retry_inc;
                            r_timer       <= '0;
                            r_lock        <= 1'b0;
                            if (w_retry_exh) begin
                                r_state <= ST_FAIL;
                                r_fail  <= 1'b1;
                            end else begin
                                r_state    <= ST_ARM;
                                r_research <= 1'b1;
                                r_fail     <= 1'b0;
                            end
                        end else begin
                            r_state <= ST_WAIT_SYNC;
                            r_timer <= r_timer + TMR_W'(1);
                            r_lock  <= 1'b0;
                            r_fail  <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        r_fail <= 1'b0;
                        if (bus.I_Packet_Done) begin
                            r_state <= ST_IDLE;
                            r_lock  <= 1'b0;
                        end else if (bus.I_Ecc_Error && w_ecc_lim) begin
                            r_state         <= ST_ARM;
                            r_research      <= 1'b1;
                            r_lock          <= 1'b0;
                            r_ecc           <= '0;
                            r_lock_lost_cnt <= sat_inc(r_lock_lost_cnt);
                        end else if (bus.I_Ecc_Error) begin
                            r_state <= ST_LOCKED;
                            r_ecc   <= w_ecc_inc;
                            r_lock  <= 1'b1;
                        end else begin
                            r_state <= ST_LOCKED;
                            r_lock  <= 1'b1;
                        end
                    end
                    ST_FAIL: begin
                        r_state <= ST_FAIL;
                        r_lock  <= 1'b0;
                        r_fail  <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_retry <= '0;
                        r_ecc   <= '0;
                        r_lock  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.O_ReSearch_Offset = r_research;
    assign bus.O_Lock            = r_lock;
    assign bus.O_Fail            = r_fail;
    assign bus.O_State           = r_state;
    assign bus.O_Lock_Lost_Cnt   = r_lock_lost_cnt;
    assign bus.O_Timeout_Cnt     = r_timeout_cnt;

endmodule

// File: tb/tb_mipi_byte_align_ctrl.sv
// Bench for mipi_byte_align_ctrl: table of per-cycle vectors plus long multi-cycle sequences,
// with a second small instance (CNT_W=2, SYNC_TIMEOUT=4) for counter saturation.
module tb_mipi_byte_align_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   rs_pulses;

    mipi_byte_align_ctrl_if #(.CNT_W(16)) bus_a ();
    mipi_byte_align_ctrl_if #(.CNT_W(2))  bus_b ();

    mipi_byte_align_ctrl #(
        .SYNC_TIMEOUT(64), .ERR_LIMIT(2), .MAX_RETRY(8), .CNT_W(16)
    ) u_dut_a (
        .I_CLK   (clk),
        .I_Rst_n (rst_n),
        .bus     (bus_a)
    );

    mipi_byte_align_ctrl #(
        .SYNC_TIMEOUT(4), .ERR_LIMIT(2), .MAX_RETRY(8), .CNT_W(2)
    ) u_dut_b (
        .I_CLK   (clk),
        .I_Rst_n (rst_n),
        .bus     (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus_a.O_ReSearch_Offset === 1'b1) rs_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       nm;
        logic [2:0]  st;
        logic        rs;
        logic        lk;
        logic        fl;
        logic [15:0] tc;
        logic [15:0] lc;
    } exp_t;

    typedef struct {
        string       nm;
        logic        hs;
        logic        vld;
        logic        pd;
        logic        ecc;
        logic [2:0]  st;
        logic        rs;
        logic [15:0] lc;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[20];
    logic [15:0] tc_e;
    logic [15:0] lc_e;
    int          p0;

    function automatic vec_t mk(input string nm, input logic hs, input logic vld,
                                input logic pd, input logic ecc, input logic [2:0] st,
                                input logic rs, input logic [15:0] lc);
        vec_t v;
        v.nm = nm; v.hs = hs; v.vld = vld; v.pd = pd; v.ecc = ecc;
        v.st = st; v.rs = rs; v.lc = lc;
        return v;
    endfunction

    task automatic push_exp(input string nm, input logic [2:0] st, input logic rs,
                            input logic [15:0] tc, input logic [15:0] lc);
        exp_t e;
        e.nm = nm; e.st = st; e.rs = rs;
        e.lk = (st == 3'd3);
        e.fl = (st == 3'd4);
        e.tc = tc; e.lc = lc;
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus_a.O_State !== e.st || bus_a.O_ReSearch_Offset !== e.rs ||
            bus_a.O_Lock !== e.lk || bus_a.O_Fail !== e.fl ||
            bus_a.O_Timeout_Cnt !== e.tc || bus_a.O_Lock_Lost_Cnt !== e.lc) begin
            errors++;
            $display("FAIL %s: got st=%0d rs=%0b lk=%0b fl=%0b tc=%0d lc=%0d, required st=%0d rs=%0b lk=%0b fl=%0b tc=%0d lc=%0d",
                     e.nm, bus_a.O_State, bus_a.O_ReSearch_Offset, bus_a.O_Lock, bus_a.O_Fail,
                     bus_a.O_Timeout_Cnt, bus_a.O_Lock_Lost_Cnt,
                     e.st, e.rs, e.lk, e.fl, e.tc, e.lc);
        end
    endtask

    task automatic tick(input string nm, input logic hs, input logic vld, input logic pd,
                        input logic ecc, input logic [2:0] st, input logic rs);
        bus_a.I_Lane_HS_Active = hs;
        bus_a.I_Align_Vaild    = vld;
        bus_a.I_Packet_Done    = pd;
        bus_a.I_Ecc_Error      = ecc;
        push_exp(nm, st, rs, tc_e, lc_e);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tc_e   = 16'd0;
        lc_e   = 16'd0;
        rst_n  = 1'b1;
        bus_a.I_Lane_HS_Active = 1'b0; bus_a.I_Align_Vaild = 1'b0;
        bus_a.I_Packet_Done    = 1'b0; bus_a.I_Ecc_Error   = 1'b0;
        bus_b.I_Lane_HS_Active = 1'b0; bus_b.I_Align_Vaild = 1'b0;
        bus_b.I_Packet_Done    = 1'b0; bus_b.I_Ecc_Error   = 1'b0;

        tbl[0]  = mk("nom_arm",      1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 16'd0);
        tbl[1]  = mk("nom_wait0",    1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 16'd0);
        tbl[2]  = mk("nom_wait1",    1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 16'd0);
        tbl[3]  = mk("nom_wait2",    1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 16'd0);
        tbl[4]  = mk("nom_wait3",    1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 16'd0);
        tbl[5]  = mk("nom_wait4",    1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 16'd0);
        tbl[6]  = mk("nom_lock",     1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 16'd0);
        tbl[7]  = mk("vld_drop_ign", 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 16'd0);
        tbl[8]  = mk("pkt_done",     1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd0);
        tbl[9]  = mk("ecc_arm",      1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 16'd0);
        tbl[10] = mk("ecc_wait",     1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 16'd0);
        tbl[11] = mk("ecc_lock",     1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 16'd0);
        tbl[12] = mk("ecc_first",    1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'd0);
        tbl[13] = mk("ecc_quiet",    1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 16'd0);
        tbl[14] = mk("ecc_limit",    1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 16'd1);
        tbl[15] = mk("ecc_rewait",   1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 16'd1);
        tbl[16] = mk("ecc_relock",   1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 16'd1);
        tbl[17] = mk("ecc_cnt_clr",  1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'd1);
        tbl[18] = mk("pd_beats_ecc", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'd1);
        tbl[19] = mk("idle_hold",    1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd1);

        // Reset state
        #2 rst_n = 1'b0;
        #4;
        push_exp("reset_a", 3'd0, 1'b0, 16'd0, 16'd0);
        compare_pop();
        chk("reset_b_state", 16'(bus_b.O_State), 16'd0);
        chk("reset_b_tcnt",  16'(bus_b.O_Timeout_Cnt), 16'd0);
        #16 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: nominal lock, packet done, ECC re-search, simultaneous events
        for (int i = 0; i < 20; i++) begin
            lc_e = tbl[i].lc;
            tick(tbl[i].nm, tbl[i].hs, tbl[i].vld, tbl[i].pd, tbl[i].ecc, tbl[i].st, tbl[i].rs);
        end
        chk("lock_lost_cnt", bus_a.O_Lock_Lost_Cnt, 16'd1);

        // Timeout/retry until FAIL
        p0 = rs_pulses;
        tick("to_arm", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 64; k++) tick("to_wait", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
            tc_e = tc_e + 16'd1;
            if (r < 7) tick("to_retry", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
            else       tick("to_fail",  1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0);
        end
        chk("to_pulses", 16'(rs_pulses - p0), 16'd8);
        chk("to_cnt8", bus_a.O_Timeout_Cnt, 16'd8);
        for (int k = 0; k < 3; k++) tick("fail_ign_vld", 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
        tick("fail_drop", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Lane drop mid-wait; re-entry gets a full window and fresh retry count
        tick("ld_arm", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        for (int k = 0; k < 30; k++) tick("ld_wait", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        tick("ld_drop", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick("ld_rearm", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        for (int k = 0; k < 64; k++) tick("ld_full_win", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        tc_e = tc_e + 16'd1;
        tick("ld_retry1", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        tick("ld_drop2", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Valid on the timeout cycle wins
        tick("vt_arm", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        for (int k = 0; k < 64; k++) tick("vt_wait", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        tick("vt_lock", 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
        chk("vt_tcnt", bus_a.O_Timeout_Cnt, 16'd9);
        tick("vt_pd", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        // Async reset mid-LOCKED, away from the clock edge
        tick("ar_arm", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        tick("ar_wait", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        tick("ar_lock", 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        tc_e = 16'd0;
        lc_e = 16'd0;
        push_exp("ar_reset", 3'd0, 1'b0, tc_e, lc_e);
        compare_pop();
        bus_a.I_Lane_HS_Active = 1'b0;
        bus_a.I_Align_Vaild    = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Counter saturation on the small instance: timeout k lands at edge 1+5k
        bus_b.I_Lane_HS_Active = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        chk("sat_cnt2", 16'(bus_b.O_Timeout_Cnt), 16'd2);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_cnt3", 16'(bus_b.O_Timeout_Cnt), 16'd3);
        repeat (10) @(posedge clk);
        #1;
        chk("sat_hold", 16'(bus_b.O_Timeout_Cnt), 16'd3);
        chk("sat_state", 16'(bus_b.O_State), 16'd1);
        bus_b.I_Lane_HS_Active = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_drop", 16'(bus_b.O_State), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
